// File: rtl/bcd_updown_counter.sv
`default_nettype none
// bcd_updown_counter: DIGITS-wide BCD up/down counter with clear, validated load and carry/borrow out.
// Optional macro BCD_CNT_SATURATE_EN: hold at the terminal value instead of wrapping.
module bcd_updown_counter #(
  parameter int                  DIGITS = 3,
  parameter logic [4*DIGITS-1:0] INIT   = '0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Cin,
  input  logic                  Up_Dn,
  input  logic                  Clr,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Load_data,
  output logic                  Cout,
  output logic [4*DIGITS-1:0]   q,
  output logic                  Load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] stepped;
  logic         ripple;
  logic         at_terminal;
  logic         load_ok;
  logic         sat_hold;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (Load_data[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple the +1/-1 from digit 0 upward; a surviving ripple means q was already terminal.
  always_comb begin
    stepped = q;
    ripple  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (Up_Dn) begin
          if (q[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = q[4*i +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = q[4*i +: 4] - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
    at_terminal = ripple;
  end

`ifdef BCD_CNT_SATURATE_EN
  assign sat_hold = at_terminal;
`else
  assign sat_hold = 1'b0;
`endif

  assign Cout = Cin & ~Clr & ~Load & at_terminal;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q        <= INIT;
      Load_err <= 1'b0;
    end else begin
      Load_err <= 1'b0;
      if (Clr) begin
        q <= '0;
      end else if (Load) begin
        if (load_ok) q <= Load_data;
        else         Load_err <= 1'b1;
      end else if (Cin && !sat_hold) begin
        q <= stepped;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter; the next generation of the team's cascaded three-digit up-counter. Digit count is a parameter, and the block counts up or down, supports synchronous clear and parallel load with BCD validity checking, and produces a carry/borrow output for cascading into further stages. It sits wherever a decimal event count or a display-ready count value is needed, such as frequency meters and timer displays.

## Interface
- `DIGITS`, default 3: number of BCD digits (1..8); count width is 4*DIGITS.
- `INIT`, default 0: BCD reset value, 4*DIGITS bits; every nibble must be ≤ 9.

- `Clk` input 1: count clock, rising edge.
- `Rst_n` input 1: asynchronous reset, active-low.
- `Cin` input 1: count enable/carry-in; one step per cycle while high.
- `Up_Dn` input 1: direction; 1 = up, 0 = down. Sampled only when `Cin` = 1.
- `Clr` input 1: synchronous clear to 0.
- `Load` input 1: synchronous parallel load.
- `Load_data` input 4*DIGITS: BCD value to load; digit 0 is in bits [3:0].
- `Cout` output 1: carry (up) or borrow (down). Combinational.
- `q` output 4*DIGITS: count value, BCD, digit 0 is least significant. Registered.
- `Load_err` output 1: one-cycle pulse flagging a rejected load. Registered.

## Operation
- Per-cycle action, in priority order:
  1. `Clr` = 1: `q` ← 0.
  2. else `Load` = 1 and every nibble of `Load_data` ≤ 9: `q` ← `Load_data`.
  3. else `Load` = 1 with any nibble > 9: `q` holds; `Load_err` = 1 next cycle.
  4. else `Cin` = 1: count one step in the `Up_Dn` direction.
  5. else: hold.
- `Load_err` is evaluated only when `Load` wins priority. `Clr` + invalid `Load` does not pulse it.
- Up step: digit 0 +1. A digit at 9 goes to 0 and propagates +1 to the next digit; this is standard BCD ripple evaluated within one cycle.
- Down step: digit 0 −1. A digit at 0 goes to 9 and propagates −1.
- Terminal value is all-9s when counting up and all-0s when counting down.
- `Cout` = `Cin` & ~`Clr` & ~`Load` & (`q` == terminal for the current `Up_Dn`).
- Wrap (default): up from all-9s → 0; down from 0 → all-9s. `Cout` is high in the wrapping cycle.
- Cascading: `Cout` of stage N drives `Cin` of stage N+1, with `Up_Dn` common to both. The combined counter behaves as one longer counter.
- `Up_Dn` changing between cycles takes effect on the next step, with no extra latency.
- `q` never holds a non-BCD nibble under any input sequence.

## Timing
- Reset (`Rst_n` low, asynchronous, any time including mid-count): `q` = `INIT`, `Load_err` = 0. `Cout` evaluates from `q` = `INIT`.
- Release of `Rst_n` is synchronised by the system. The first count step occurs on the first rising edge with `Rst_n` high and `Cin` = 1.
- `Clr`, `Load`, count: result visible on `q` one cycle after the sampling edge.
- `Load_err`: high for exactly the cycle after the rejected load. Back-to-back invalid loads give consecutive pulses.
- `Cout`: same cycle as the qualifying `Cin`, with no register, so carry ripples through cascaded stages within one cycle. The combinational path length scales with DIGITS × stages.

## Configuration
- `BCD_CNT_SATURATE_EN` defined:
  - At the terminal value a further step in the same direction holds `q` (all-9s up, 0 down) instead of wrapping.
  - `Cout` still asserts in that cycle, indicating overflow/underflow.
  - Stepping in the opposite direction leaves saturation normally.
- `BCD_CNT_SATURATE_EN` undefined: wrap behaviour as in Operation.
- `Clr` and `Load` are unaffected by the macro.

## Test plan
All scenarios use DIGITS = 3 and INIT = 0.
- Reset then `Cin` = 1, `Up_Dn` = 1 for 1000 cycles:
  - `q` steps 000→999 then 000.
  - `Cout` high only in the cycle `q` = 999.
  - No non-BCD nibble ever appears.
- Load 0x100, then `Up_Dn` = 0 with `Cin` = 1 for 2 cycles: `q` = 0x099, then 0x098. `Cout` stays 0.
- At `q` = 000 with `Up_Dn` = 0 and `Cin` = 1:
  - `Cout` = 1 that cycle.
  - Next `q` = 999 by default, or 000 with `BCD_CNT_SATURATE_EN`.
- Invalid load and priority:
  - `Load` with `Load_data` = 0x1A5: `q` holds and `Load_err` pulses for 1 cycle.
  - `Load` and `Clr` together with 0x1A5: `q` = 000 and no `Load_err`.
  - `Load` and `Cin` together with 0x456: `q` = 0x456 and `Cout` = 0.
- Drive `Rst_n` low asynchronously mid-cycle at `q` = 0x537: `q` = 000 immediately, before the next edge, and `Load_err` = 0.
- Cascade two instances (DIGITS = 3) via `Cout` → `Cin`, count up from 0x000999:
  - One step gives 0x001000.
  - Down one step from 0x001000 gives 0x000999.
